// File: rtl/nios_to_pb_passer_if.sv
// NIOS PIO pair plus packet-buffer write port of the NIOS->PB passer.
// master = NIOS/bench side, slave = the passer itself.
interface nios_to_pb_passer_if;
    logic        do_receive;
    logic [31:0] nios_out_signals;
    logic [31:0] nios_in_signals;
    logic [8:0]  pb_address_proc_write;
    logic [15:0] pb_data_proc_write;
    logic        pb_wren_proc_write;
    logic        received;

    modport master (
        output do_receive, nios_out_signals,
        input  nios_in_signals, pb_address_proc_write, pb_data_proc_write,
               pb_wren_proc_write, received
    );

    modport slave (
        input  do_receive, nios_out_signals,
        output nios_in_signals, pb_address_proc_write, pb_data_proc_write,
               pb_wren_proc_write, received
    );
endinterface

// File: rtl/nios_to_pb_passer.sv
// Pulls NUM_WORDS 16-bit words from the NIOS over a four-phase PIO handshake
// and writes them into the packet buffer starting at BASE_ADDR.
module nios_to_pb_passer #(
    parameter int         NUM_WORDS = 256,
    parameter logic [8:0] BASE_ADDR = 9'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    nios_to_pb_passer_if.slave io_bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ARM        = 3'd1;
    localparam logic [2:0] S_REQ        = 3'd2;
    localparam logic [2:0] S_WAIT_VALID = 3'd3;
    localparam logic [2:0] S_WRITE      = 3'd4;
    localparam logic [2:0] S_WAIT_DROP  = 3'd5;

    logic [2:0]  r_state;
    logic [8:0]  r_count;
    logic [8:0]  r_addr;
    logic [15:0] r_data;
    logic        r_wren;
    logic        r_req;
    logic        r_ack;
    logic        r_received;

    logic        w_dv;
    logic        w_rdy;
    logic        w_last;
    logic [8:0]  w_wr_addr;

    assign w_dv      = io_bus.nios_out_signals[16];
    assign w_rdy     = io_bus.nios_out_signals[30];
    assign w_last    = (r_count == 9'(NUM_WORDS));
    // 9-bit sum: addresses wrap modulo 512
    assign w_wr_addr = BASE_ADDR + r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_addr     <= BASE_ADDR;
            r_data     <= '0;
            r_wren     <= 1'b0;
            r_req      <= 1'b0;
            r_ack      <= 1'b0;
            r_received <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_count    <= '0;
                    r_wren     <= 1'b0;
                    r_received <= 1'b1;
                    if (io_bus.do_receive) r_state <= S_ARM;
                end
                S_ARM: begin
                    // Start fires on the falling edge of do_receive; req is raised
                    // on entry to REQ so a ready NIOS sees exactly one req cycle.
                    r_received <= 1'b0;
                    r_req      <= 1'b0;
                    if (!io_bus.do_receive) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_rdy) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT_VALID;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_WAIT_VALID: begin
                    if (w_dv) begin
                        r_data  <= io_bus.nios_out_signals[15:0];
                        r_addr  <= w_wr_addr;
                        r_wren  <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wren  <= 1'b0;
                    r_ack   <= 1'b1;
                    r_count <= r_count + 9'd1;
                    r_state <= S_WAIT_DROP;
                end
                S_WAIT_DROP: begin
                    if (!w_dv) begin
                        r_ack   <= 1'b0;
                        r_state <= w_last ? S_IDLE : S_WAIT_VALID;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.nios_in_signals       = {r_req, 13'b0, r_ack, 17'b0};
    assign io_bus.pb_address_proc_write = r_addr;
    assign io_bus.pb_data_proc_write    = r_data;
    assign io_bus.pb_wren_proc_write    = r_wren;
    assign io_bus.received              = r_received;
endmodule

// File: tb/tb_nios_to_pb_passer.sv
// Directed bench: three passer instances (default, 4-word, wrapping base) share one
// NIOS model; sel picks which one is stimulated and observed.
module tb_nios_to_pb_passer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        do_rx = 1'b0;
    logic        dv = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] dat = '0;
    logic [31:0] nout;
    int          sel = 0;

    assign nout = {1'b0, rdy, 13'b0, dv, dat};

    nios_to_pb_passer_if ifa ();
    nios_to_pb_passer_if ifb ();
    nios_to_pb_passer_if ifc ();

    assign ifa.do_receive = do_rx && (sel == 0);
    assign ifb.do_receive = do_rx && (sel == 1);
    assign ifc.do_receive = do_rx && (sel == 2);
    assign ifa.nios_out_signals = nout;
    assign ifb.nios_out_signals = nout;
    assign ifc.nios_out_signals = nout;

    nios_to_pb_passer #(.NUM_WORDS(256), .BASE_ADDR(9'h000)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(ifa));
    nios_to_pb_passer #(.NUM_WORDS(4),   .BASE_ADDR(9'h000)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(ifb));
    nios_to_pb_passer #(.NUM_WORDS(32),  .BASE_ADDR(9'h1F0)) dut_c (.clk(clk), .rst_n(rst_n), .io_bus(ifc));

    logic [31:0] m_in;
    logic [8:0]  m_addr;
    logic [15:0] m_data;
    logic        m_wren, m_rcv, m_req, m_ack;

    always_comb begin
        m_in = ifa.nios_in_signals; m_addr = ifa.pb_address_proc_write;
        m_data = ifa.pb_data_proc_write; m_wren = ifa.pb_wren_proc_write; m_rcv = ifa.received;
        if (sel == 1) begin
            m_in = ifb.nios_in_signals; m_addr = ifb.pb_address_proc_write;
            m_data = ifb.pb_data_proc_write; m_wren = ifb.pb_wren_proc_write; m_rcv = ifb.received;
        end else if (sel == 2) begin
            m_in = ifc.nios_in_signals; m_addr = ifc.pb_address_proc_write;
            m_data = ifc.pb_data_proc_write; m_wren = ifc.pb_wren_proc_write; m_rcv = ifc.received;
        end
    end
    assign m_req = m_in[31];
    assign m_ack = m_in[17];

    int n_chk = 0;
    int n_fail = 0;
    int wren_cnt = 0;

    always @(negedge clk) if (m_wren) wren_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input int hold, input bit pre_rdy);
        rdy = pre_rdy;
        do_rx = 1'b1;
        repeat (hold) begin
            tick();
            chk("req_low_while_held", m_req, 0);
        end
        do_rx = 1'b0;
        tick();
        chk("req_rise", m_req, 1);
        chk("rcv_busy", m_rcv, 0);
        if (!pre_rdy) begin
            tick();
            chk("req_wait_rdy", m_req, 1);
            rdy = 1'b1;
        end
        tick();
        chk("req_drop", m_req, 0);
        rdy = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [8:0] ea, input int hold);
        int k;
        dat = d;
        dv  = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!m_wren && k < 8);
        chk("wren", m_wren, 1);
        chk("addr", m_addr, ea);
        chk("data", m_data, d);
        dat = ~d;
        tick();
        chk("wren_one_cycle", m_wren, 0);
        chk("ack_high", m_ack, 1);
        chk("in_other_bits", m_in & 32'h7FFD_FFFF, 0);
        repeat (hold) begin
            tick();
            chk("ack_hold", m_ack, 1);
            chk("wren_hold", m_wren, 0);
            chk("data_hold", m_data, d);
        end
        dv = 1'b0;
        k = 0;
        do begin tick(); k++; end while (m_ack && k < 8);
        chk("ack_drop", m_ack, 0);
    endtask

    task automatic run_pkt(input int n, input logic [8:0] base, input logic [15:0] dbase, input int hold);
        int w0;
        logic [8:0] a;
        w0 = wren_cnt;
        for (int i = 0; i < n; i++) begin
            a = base + 9'(i);
            send_word(dbase + 16'(i), a, hold);
            if (i < n - 1) chk("rcv_mid_packet", m_rcv, 0);
        end
        chk("rcv_at_ack_drop", m_rcv, 0);
        tick();
        chk("rcv_after_done", m_rcv, 1);
        tick();
        chk("wren_pulses", 32'(wren_cnt - w0), 32'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        sel = 0;
        chk("rst_received", m_rcv, 1);
        chk("rst_in_signals", m_in, 0);
        chk("rst_wren", m_wren, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_data", m_data, 0);
        sel = 2;
        #1 chk("rst_addr_base", m_addr, 9'h1F0);
        rst_n = 1'b1;
        tick();

        // full 256-word packet, data equals address
        sel = 0;
        start(1, 1'b0);
        run_pkt(256, 9'h000, 16'h0000, 0);

        // NIOS already ready before the start
        start(1, 1'b1);
        run_pkt(256, 9'h000, 16'hC000, 0);

        // held do_receive gives one packet only
        sel = 1;
        start(50, 1'b0);
        run_pkt(4, 9'h000, 16'h2000, 0);
        repeat (20) begin
            tick();
            chk("no_restart", m_in, 0);
        end
        chk("still_idle", m_rcv, 1);

        // slow NIOS holds data_valid 20 cycles per word
        start(1, 1'b0);
        run_pkt(4, 9'h000, 16'h3000, 20);

        // wrapping address range
        sel = 2;
        start(1, 1'b0);
        run_pkt(32, 9'h1F0, 16'h6000, 0);

        // reset in the middle of a transfer
        sel = 0;
        start(1, 1'b0);
        for (int i = 0; i < 100; i++) send_word(16'(i), 9'(i), 0);
        dat = 16'd100;
        dv  = 1'b1;
        tick();
        chk("pre_rst_wren", m_wren, 1);
        tick();
        chk("pre_rst_ack", m_ack, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wren", m_wren, 0);
        chk("rst_mid_in", m_in, 0);
        chk("rst_mid_rcv", m_rcv, 1);
        chk("rst_mid_addr", m_addr, 0);
        dv = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start(1, 1'b0);
        send_word(16'h5555, 9'h000, 0);
        send_word(16'h5556, 9'h001, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
